// File: rtl/lob_pkg.sv
// -----------------------------------------------------------------------------
// lob_pkg
// Shared definitions for the limit-order-book cancel/modify path.
//   - default field widths and the packed word-width helper
//   - EMPTY / DELETED sentinel words (wide enough for any legal width;
//     users slice the low W bits)
//   - completion status codes and side encoding
// -----------------------------------------------------------------------------
package lob_pkg;

  localparam int ID_W_DEF    = 16;
  localparam int PRICE_W_DEF = 16;
  localparam int QTY_W_DEF   = 16;

  // Upper bound on a book word; sentinels are declared at this width.
  localparam int MAX_W = 192;

  // Width of one packed {id, price, qty} book entry.
  function automatic int word_w(input int id_w, input int price_w, input int qty_w);
    return id_w + price_w + qty_w;
  endfunction

  // All-zero entry terminates a side; all-one entry is a tombstone.
  localparam logic [MAX_W-1:0] EMPTY_WORD   = {MAX_W{1'b0}};
  localparam logic [MAX_W-1:0] DELETED_WORD = {MAX_W{1'b1}};

  typedef logic [1:0] status_t;

  localparam status_t ST_NOTFOUND  = 2'b00;
  localparam status_t ST_CANCELLED = 2'b01;
  localparam status_t ST_REDUCED   = 2'b10;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

endpackage

// File: rtl/order_book_ram.sv
// -----------------------------------------------------------------------------
// order_book_ram
// Single-port book RAM for one side. Synchronous read with one cycle of
// latency; a write returns the written word on rdata (write-first).
// Contents are not reset.
// Ports:
//   clk    system clock
//   we     write enable
//   addr   entry address
//   wdata  word to write
//   rdata  word at addr, registered
// -----------------------------------------------------------------------------
module order_book_ram #(
  parameter int W     = 48,
  parameter int DEPTH = 4096,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Storage array and registered read port (write-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
      rdata       <= wdata;
    end else begin
      rdata       <= mem_r[addr];
    end
  end

endmodule

// File: rtl/order_cancel_engine.sv
// -----------------------------------------------------------------------------
// order_cancel_engine
// Finds a resting order by ID in the buy book, the sell book, or both (buy
// first) and either deletes it or reduces its quantity. Owns both side RAMs;
// a host port preloads/maintains them while no search is running.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start              request strobe, taken only when idle
//   req_id/side/mode/qty  request: ID, side mask {sell,buy}, 0 cancel / 1 reduce, amount
//   wr_en/side/addr/data  host RAM write
//   busy, done         search in progress, one-cycle completion pulse
//   status             00 not found, 01 cancelled, 10 reduced
//   hit_side/hit_addr  location of the match
//   rem_qty            quantity left after the operation
// -----------------------------------------------------------------------------
module order_cancel_engine
  import lob_pkg::*;
#(
  parameter int ID_W       = ID_W_DEF,
  parameter int PRICE_W    = PRICE_W_DEF,
  parameter int QTY_W      = QTY_W_DEF,
  parameter int DEPTH      = 4096,
  parameter int ADDR_W     = 12,
  parameter int SCAN_LIMIT = DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ID_W-1:0]                 req_id,
  input  logic [1:0]                      req_side,
  input  logic                            req_mode,
  input  logic [QTY_W-1:0]                req_qty,
  input  logic                            wr_en,
  input  logic                            wr_side,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [ID_W+PRICE_W+QTY_W-1:0]   wr_data,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      status,
  output logic                            hit_side,
  output logic [ADDR_W-1:0]               hit_addr,
  output logic [QTY_W-1:0]                rem_qty
);

  localparam int W      = word_w(ID_W, PRICE_W, QTY_W);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [W-1:0]      EMPTY_W   = EMPTY_WORD[W-1:0];
  localparam logic [W-1:0]      DELETED_W = DELETED_WORD[W-1:0];
  localparam logic [ID_W-1:0]   ID_RSVD   = {ID_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SCAN_LIMIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic              side_r;
  logic [ID_W-1:0]   req_id_r;
  logic [1:0]        req_side_r;
  logic              req_mode_r;
  logic [QTY_W-1:0]  req_qty_r;
  logic [W-1:0]      word_r;
  logic              busy_r;
  logic              done_r;
  status_t           status_r;
  logic              hit_side_r;
  logic [ADDR_W-1:0] hit_addr_r;
  logic [QTY_W-1:0]  rem_qty_r;

  logic [W-1:0]      buy_rdata_s;
  logic [W-1:0]      sell_rdata_s;
  logic [W-1:0]      rd_word_s;
  logic              is_empty_s;
  logic              id_match_s;
  logic              host_owns_s;

  logic              wb_we_s;
  logic [W-1:0]      wb_word_s;
  status_t           wb_status_s;
  logic [QTY_W-1:0]  wb_rem_s;
  logic [QTY_W-1:0]  word_qty_s;

  logic              buy_we_s;
  logic              sell_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [W-1:0]      ram_wdata_s;

  // Word under inspection and its classification for the CHECK state.
  always_comb begin
    rd_word_s  = (side_r == SIDE_SELL) ? sell_rdata_s : buy_rdata_s;
    is_empty_s = (rd_word_s == EMPTY_W);
    // Tombstones and the reserved ID never match, whatever their ID field holds.
    id_match_s = (rd_word_s[W-1 -: ID_W] == req_id_r) &&
                 (rd_word_s != DELETED_W) &&
                 (req_id_r != ID_RSVD);
  end

  // Write-back word and result for the matched entry (held in word_r).
  always_comb begin
    word_qty_s  = word_r[QTY_W-1:0];
    wb_we_s     = 1'b1;
    wb_word_s   = DELETED_W;
    wb_status_s = ST_CANCELLED;
    wb_rem_s    = {QTY_W{1'b0}};
    if (req_mode_r == 1'b0) begin
      wb_we_s     = 1'b1;
      wb_word_s   = DELETED_W;
      wb_status_s = ST_CANCELLED;
      wb_rem_s    = {QTY_W{1'b0}};
    end else if (req_qty_r == {QTY_W{1'b0}}) begin
      // Zero reduce reports success but leaves the entry untouched.
      wb_we_s     = 1'b0;
      wb_word_s   = word_r;
      wb_status_s = ST_REDUCED;
      wb_rem_s    = word_qty_s;
    end else if (req_qty_r < word_qty_s) begin
      wb_we_s     = 1'b1;
      wb_word_s   = {word_r[W-1:QTY_W], word_qty_s - req_qty_r};
      wb_status_s = ST_REDUCED;
      wb_rem_s    = word_qty_s - req_qty_r;
    end else begin
      // Reducing by the full quantity or more removes the order.
      wb_we_s     = 1'b1;
      wb_word_s   = DELETED_W;
      wb_status_s = ST_CANCELLED;
      wb_rem_s    = {QTY_W{1'b0}};
    end
  end

  // RAM port arbitration: the host owns both ports whenever no scan is in flight.
  always_comb begin
    host_owns_s = (state_r == S_IDLE) || (state_r == S_DONE);
    if (host_owns_s) begin
      ram_addr_s  = wr_addr;
      ram_wdata_s = wr_data;
      buy_we_s    = wr_en && (wr_side == SIDE_BUY);
      sell_we_s   = wr_en && (wr_side == SIDE_SELL);
    end else begin
      ram_addr_s  = idx_r;
      ram_wdata_s = wb_word_s;
      buy_we_s    = (state_r == S_WRITE) && wb_we_s && (side_r == SIDE_BUY);
      sell_we_s   = (state_r == S_WRITE) && wb_we_s && (side_r == SIDE_SELL);
    end
  end

  order_book_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_buy_ram (
    .clk   (clk),
    .we    (buy_we_s),
    .addr  (ram_addr_s[RAM_AW-1:0]),
    .wdata (ram_wdata_s),
    .rdata (buy_rdata_s)
  );

  order_book_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_sell_ram (
    .clk   (clk),
    .we    (sell_we_s),
    .addr  (ram_addr_s[RAM_AW-1:0]),
    .wdata (ram_wdata_s),
    .rdata (sell_rdata_s)
  );

  // Search sequencer: request capture, scan, write-back and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      idx_r      <= IDX_ZERO;
      side_r     <= SIDE_BUY;
      req_id_r   <= {ID_W{1'b0}};
      req_side_r <= 2'b00;
      req_mode_r <= 1'b0;
      req_qty_r  <= {QTY_W{1'b0}};
      word_r     <= {W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      status_r   <= ST_NOTFOUND;
      hit_side_r <= 1'b0;
      hit_addr_r <= IDX_ZERO;
      rem_qty_r  <= {QTY_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            req_id_r   <= req_id;
            req_side_r <= req_side;
            req_mode_r <= req_mode;
            req_qty_r  <= req_qty;
            idx_r      <= IDX_ZERO;
            status_r   <= ST_NOTFOUND;
            hit_side_r <= 1'b0;
            hit_addr_r <= IDX_ZERO;
            rem_qty_r  <= {QTY_W{1'b0}};
            if (req_side == 2'b00) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= S_ADDR;
              busy_r  <= 1'b1;
              side_r  <= req_side[0] ? SIDE_BUY : SIDE_SELL;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ADDR: begin
          state_r <= S_CHECK;
        end
        S_CHECK: begin
          // A match on the last scanned entry still wins over the scan limit.
          if (is_empty_s) begin
            state_r <= S_NEXT;
          end else if (id_match_s) begin
            word_r  <= rd_word_s;
            state_r <= S_WRITE;
          end else if (idx_r == LAST_IDX) begin
            state_r <= S_NEXT;
          end else begin
            idx_r   <= idx_r + IDX_ONE;
            state_r <= S_ADDR;
          end
        end
        S_WRITE: begin
          status_r   <= wb_status_s;
          rem_qty_r  <= wb_rem_s;
          hit_side_r <= side_r;
          hit_addr_r <= idx_r;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= S_DONE;
        end
        S_NEXT: begin
          if ((side_r == SIDE_BUY) && req_side_r[1]) begin
            side_r  <= SIDE_SELL;
            idx_r   <= IDX_ZERO;
            state_r <= S_ADDR;
          end else begin
            status_r <= ST_NOTFOUND;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= S_DONE;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign status   = status_r;
  assign hit_side = hit_side_r;
  assign hit_addr = hit_addr_r;
  assign rem_qty  = rem_qty_r;

endmodule

// File: tb/tb_order_cancel_engine.sv
// -----------------------------------------------------------------------------
// tb_order_cancel_engine
// Directed scenarios followed by randomized books and requests, checked
// against an array-based model of the order books.
// -----------------------------------------------------------------------------
module tb_order_cancel_engine;

  localparam int SCAN = 10;
  localparam int NENT = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] req_id;
  logic [1:0]  req_side;
  logic        req_mode;
  logic [15:0] req_qty;
  logic        wr_en;
  logic        wr_side;
  logic [3:0]  wr_addr;
  logic [47:0] wr_data;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic        hit_side;
  logic [3:0]  hit_addr;
  logic [15:0] rem_qty;

  int checks = 0;
  int errors = 0;

  // Model of both books: index 0 = buy, 1 = sell.
  logic [47:0] bk [2][NENT];

  order_cancel_engine #(
    .ID_W(16), .PRICE_W(16), .QTY_W(16),
    .DEPTH(NENT), .ADDR_W(4), .SCAN_LIMIT(SCAN)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .req_id(req_id), .req_side(req_side), .req_mode(req_mode), .req_qty(req_qty),
    .wr_en(wr_en), .wr_side(wr_side), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .status(status),
    .hit_side(hit_side), .hit_addr(hit_addr), .rem_qty(rem_qty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] mk(input logic [15:0] id, input logic [15:0] pr,
                                     input logic [15:0] q);
    return {id, pr, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first live match, buy before sell; updates the model books.
  task automatic model_op(input logic [15:0] id, input logic [1:0] mask,
                          input logic mode, input logic [15:0] qty,
                          output logic [1:0] est, output logic eside,
                          output logic [3:0] eaddr, output logic [15:0] erem,
                          output int ecyc);
    bit found;
    int fs, fa;
    logic [47:0] w;
    logic [15:0] q;
    found = 0; fs = 0; fa = 0;
    ecyc = 1;                        // the done cycle
    est = 2'b00; eside = 1'b0; eaddr = 4'd0; erem = 16'd0;
    for (int s = 0; s < 2; s++) begin
      if (mask[s] && !found) begin
        for (int i = 0; i < SCAN; i++) begin
          w = bk[s][i];
          ecyc += 2;                 // address + compare per entry
          if (w == 48'd0) break;
          if (w != {48{1'b1}} && w[47:32] == id && id != 16'hFFFF) begin
            found = 1; fs = s; fa = i;
            break;
          end
        end
        if (!found) ecyc += 1;       // side transition
      end
    end
    if (found) begin
      ecyc += 1;                     // write-back cycle
      q = bk[fs][fa][15:0];
      eside = fs[0];
      eaddr = fa[3:0];
      if (mode == 1'b0 || (qty != 16'd0 && qty >= q)) begin
        bk[fs][fa] = {48{1'b1}};
        est = 2'b01; erem = 16'd0;
      end else if (qty == 16'd0) begin
        est = 2'b10; erem = q;
      end else begin
        bk[fs][fa][15:0] = q - qty;
        est = 2'b10; erem = q - qty;
      end
    end
  endtask

  task automatic host_write(input logic s, input logic [3:0] a, input logic [47:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_side = s; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_books();
    for (int i = 0; i < NENT; i++) begin
      host_write(1'b0, i[3:0], bk[0][i]);
      host_write(1'b1, i[3:0], bk[1][i]);
    end
  endtask

  task automatic check_books();
    for (int i = 0; i < NENT; i++) begin
      check("buy_ram", dut.u_buy_ram.mem_r[i], bk[0][i]);
      check("sell_ram", dut.u_sell_ram.mem_r[i], bk[1][i]);
    end
  endtask

  // Issue one request; optionally pulse a stray start at cycle pulse_at.
  task automatic run_op(input logic [15:0] id, input logic [1:0] mask, input logic mode,
                        input logic [15:0] qty, input int pulse_at, input logic [15:0] pulse_id);
    logic [1:0]  es;
    logic        eside;
    logic [3:0]  eaddr;
    logic [15:0] erem;
    int          ecyc;
    int          n;
    bit          seen;
    model_op(id, mask, mode, qty, es, eside, eaddr, erem, ecyc);
    @(negedge clk);
    req_id = id; req_side = mask; req_mode = mode; req_qty = qty; start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == pulse_at) begin
        start = 1'b1; req_id = pulse_id; req_mode = 1'b0;
      end
      if (n == 1) check("busy_rise", busy, (ecyc > 1));
      if (done) seen = 1;
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    check("latency", n, ecyc);
    check("busy_at_done", busy, 1'b0);
    check("status", status, es);
    if (es != 2'b00) begin
      check("hit_side", hit_side, eside);
      check("hit_addr", hit_addr, eaddr);
      check("rem_qty", rem_qty, erem);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    check_books();
  endtask

  initial begin
    logic [1:0]  rmask;
    logic [15:0] rid;
    int          r;

    rst = 1'b0; start = 1'b0; req_id = 16'd0; req_side = 2'b00; req_mode = 1'b0;
    req_qty = 16'd0; wr_en = 1'b0; wr_side = 1'b0; wr_addr = 4'd0; wr_data = 48'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'b00);
    check("rst_hit_side", hit_side, 1'b0);
    check("rst_hit_addr", hit_addr, 4'd0);
    check("rst_rem_qty", rem_qty, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed book: buy ids 5,7,9 then EMPTY; sell ids 20..23, id 9 at 4, then EMPTY.
    for (int i = 0; i < NENT; i++) begin
      bk[0][i] = 48'd0;
      bk[1][i] = 48'd0;
    end
    bk[0][0] = mk(16'd5, 16'd1000, 16'd100);
    bk[0][1] = mk(16'd7, 16'd1001, 16'd100);
    bk[0][2] = mk(16'd9, 16'd1002, 16'd100);
    for (int i = 0; i < 4; i++) bk[1][i] = mk(16'd20 + 16'(i), 16'd2000, 16'd10);
    bk[1][4] = mk(16'd9, 16'd2004, 16'd50);
    load_books();

    run_op(16'd7, 2'b01, 1'b0, 16'd0, 0, 16'd0);   // cancel id 7, 6 cycles
    run_op(16'd9, 2'b11, 1'b1, 16'd30, 0, 16'd0);  // reduce id 9 by 30 on buy
    bk[0][2] = {48{1'b1}};
    host_write(1'b0, 4'd2, bk[0][2]);
    run_op(16'd9, 2'b11, 1'b0, 16'd0, 0, 16'd0);   // hit on sell[4]
    run_op(16'd5, 2'b01, 1'b1, 16'd150, 0, 16'd0); // over-reduce deletes
    run_op(16'd3, 2'b00, 1'b0, 16'd0, 0, 16'd0);   // empty mask

    // Full books of non-matching ids; stray start mid-scan targets a live id.
    for (int i = 0; i < NENT; i++) begin
      bk[0][i] = mk(16'd100 + 16'(i), 16'd300, 16'd5);
      bk[1][i] = mk(16'd200 + 16'(i), 16'd400, 16'd5);
    end
    load_books();
    run_op(16'd42, 2'b11, 1'b0, 16'd0, 5, 16'd100);

    // Reset while comparing a matching entry: no write-back may follow.
    for (int i = 0; i < NENT; i++) begin
      bk[0][i] = 48'd0;
      bk[1][i] = 48'd0;
    end
    bk[0][0] = mk(16'd1, 16'd500, 16'd40);
    bk[0][1] = mk(16'd2, 16'd501, 16'd40);
    load_books();
    @(negedge clk);
    req_id = 16'd2; req_side = 2'b01; req_mode = 1'b0; req_qty = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_scan", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_status", status, 2'b00);
    check("rst_mid_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    check_books();
    run_op(16'd2, 2'b01, 1'b0, 16'd0, 0, 16'd0);

    // Randomized books and requests.
    for (int round = 0; round < 25; round++) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < NENT; i++) begin
          r = $urandom_range(0, 9);
          if (r == 0)      bk[s][i] = 48'd0;
          else if (r == 1) bk[s][i] = {48{1'b1}};
          else if (r == 2) bk[s][i] = mk(16'hFFFF, 16'($urandom_range(0, 65535)),
                                         16'($urandom_range(0, 200)));
          else             bk[s][i] = mk(16'($urandom_range(1, 6)),
                                         16'($urandom_range(0, 65535)),
                                         16'($urandom_range(0, 200)));
        end
      end
      load_books();
      for (int k = 0; k < 3; k++) begin
        rid   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
        rmask = 2'($urandom_range(0, 3));
        run_op(rid, rmask, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 220)), 0, 16'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
